// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit ALU: op encoding, flag bit positions and widths.
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int OP_W   = 4;
    localparam int FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Ops that drive the shared adder in subtract mode (b inverted, carry-in 1).
    function automatic logic is_sub_op(input logic [OP_W-1:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

    // Ops whose C and V flags come from the adder; everything else forces them to 0.
    function automatic logic is_arith_op(input logic [OP_W-1:0] op);
        return (op == ALU_ADD) || is_sub_op(op);
    endfunction

endpackage

// File: rtl/alu_adder.sv
// 32-bit ripple-style adder with carry-in; reports carry out of bit 31 and signed overflow.
module alu_adder
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cin,
    output logic [XLEN-1:0] sum,
    output logic            cout,
    output logic            ovf
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};

    // Overflow: same-sign operands (b as presented, i.e. already inverted for subtract)
    // yielding a sum of the opposite sign.
    assign ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

endmodule

// File: rtl/alu_unit.sv
// Combinational 32-bit ALU with registered result/flags capture.
// Define ALU_SHIFT_EN to build the barrel shifter; otherwise ops 5-7 act as reserved.
module alu_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [OP_W-1:0]   op,
    output logic [XLEN-1:0]   res,
    output logic [FLAG_W-1:0] flags,
    output logic [XLEN-1:0]   res_q,
    output logic [FLAG_W-1:0] flags_q
);

    logic            sub_mode;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] add_sum;
    logic            add_cout;
    logic            add_ovf;

    assign sub_mode = is_sub_op(op);
    assign add_b    = sub_mode ? ~b : b;

    alu_adder u_adder (
        .a    (a),
        .b    (add_b),
        .cin  (sub_mode),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

`ifdef ALU_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = b[4:0];
`endif

    always_comb begin
        // NOTE: default first so every path assigns res and no latch is inferred.
        res = '0;
        case (op)
            ALU_ADD,
            ALU_SUB:  res = add_sum;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
`ifdef ALU_SHIFT_EN
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = XLEN'($signed(a) >>> shamt);
`endif
            // Signed less-than is N xor V of a-b; unsigned less-than is a borrow.
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, add_sum[XLEN-1] ^ add_ovf};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, ~add_cout};
            default:  res = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = res[XLEN-1];
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_C] = is_arith_op(op) & add_cout;
        flags[FLAG_V] = is_arith_op(op) & add_ovf;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for state; reset is synchronous and wins over capture.
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            res_q   <= res;
            flags_q <= flags;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed literal vectors plus a per-cycle model compare.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;
    logic [31:0] res_q;
    logic [3:0]  flags_q;

    int n_vec  = 0;
    int n_miss = 0;

    alu_unit dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .op      (op),
        .res     (res),
        .flags   (flags),
        .res_q   (res_q),
        .flags_q (flags_q)
    );

    always #5 clk = ~clk;

    // Reference behaviour from the arithmetic definitions; returns {res, N, Z, C, V}.
    function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = $signed(x);
        longint      sy = $signed(y);
        longint      ssum = sx + sy;
        longint      sdif = sx - sy;
        logic [32:0] usum = {1'b0, x} + {1'b0, y};
        logic        add_v = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        logic        sub_v = (sdif > 64'sd2147483647) || (sdif < -64'sd2147483648);
        logic [31:0] r = 32'd0;
        logic        c = 1'b0;
        logic        v = 1'b0;
        case (o)
            4'd0: begin r = usum[31:0]; c = usum[32]; v = add_v; end
            4'd1: begin r = x - y; c = (x >= y); v = sub_v; end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
`ifdef ALU_SHIFT_EN
            4'd5: r = x << y[4:0];
            4'd6: r = x >> y[4:0];
            4'd7: r = 32'($signed(x) >>> y[4:0]);
`endif
            4'd8: begin r = (sx < sy) ? 32'd1 : 32'd0; c = (x >= y); v = sub_v; end
            4'd9: begin r = (x < y) ? 32'd1 : 32'd0; c = (x >= y); v = sub_v; end
            default: r = 32'd0;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle compare: registers against the inputs seen at the edge, comb against current inputs.
    initial begin
        logic [35:0] exp_q;
        logic [35:0] exp_c;
        forever begin
            @(posedge clk);
            exp_q = rst ? 36'd0 : model(op, a, b);
            #2;
            exp_c = model(op, a, b);
            check("res_q",   res_q,            exp_q[35:4]);
            check("flags_q", {28'd0, flags_q}, {28'd0, exp_q[3:0]});
            check("res",     res,              exp_c[35:4]);
            check("flags",   {28'd0, flags},   {28'd0, exp_c[3:0]});
        end
    end

    task automatic apply(input string name, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic [3:0] ef);
        logic [35:0] m;
        @(negedge clk);
        op = o;
        a  = x;
        b  = y;
        #1;
        m = model(o, x, y);
        check({name, " res"},         res,            er);
        check({name, " flags"},       {28'd0, flags}, {28'd0, ef});
        check({name, " model res"},   m[35:4],        er);
        check({name, " model flags"}, {28'd0, m[3:0]}, {28'd0, ef});
    endtask

    initial begin
        rst = 1'b1;
        a   = 32'd0;
        b   = 32'd0;
        op  = 4'd0;

        @(posedge clk);
        #1;
        check("reset res_q",   res_q,            32'd0);
        check("reset flags_q", {28'd0, flags_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply("add 2+3", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000);
        @(posedge clk);
        #1;
        check("res_q after 2+3", res_q, 32'd5);

        apply("add 0+0",        4'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100);
        apply("add neg+neg",    4'd0, 32'hFFFF_FFE0, 32'hFFFF_FFF9, 32'hFFFF_FFD9, 4'b1010);
        apply("add 8-7",        4'd0, 32'h0000_0008, 32'hFFFF_FFF9, 32'h0000_0001, 4'b0010);
        apply("add ovf",        4'd0, 32'h7FFF_FFF5, 32'h0000_000B, 32'h8000_0000, 4'b1001);
        apply("add 11-11",      4'd0, 32'h0000_000B, 32'hFFFF_FFF5, 32'h0000_0000, 4'b0110);
        apply("add ffff+5",     4'd0, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0004, 4'b0010);
        apply("add 20-25",      4'd0, 32'h0000_0014, 32'hFFFF_FFE7, 32'hFFFF_FFFB, 4'b1000);
        apply("add max+1",      4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        apply("add all1+1",     4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        apply("sub 5-5",        4'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
        apply("sub 3-5",        4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000);
        apply("sub min-1",      4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);
        apply("slt -1<1",       4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0010);
        apply("slt 1<-1",       4'd8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100);
        apply("sltu -1<1",      4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
        apply("and",            4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0000);
        apply("or",             4'd3, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 4'b0000);
        apply("xor",            4'd4, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'b0000);
        apply("reserved 15",    4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'b0100);
`ifdef ALU_SHIFT_EN
        apply("sra min>>4",     4'd7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b1000);
        apply("srl min>>4",     4'd6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4'b0000);
        apply("sll 1<<31",      4'd5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000);
        apply("sra by 0",       4'd7, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001, 4'b1000);
`else
        apply("sll disabled",   4'd5, 32'h0000_0001, 32'h0000_001F, 32'h0000_0000, 4'b0100);
        apply("srl disabled",   4'd6, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 4'b0100);
        apply("sra disabled",   4'd7, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 4'b0100);
`endif

        // Reset asserted while ops keep changing; registers must hold zero, comb keeps computing.
        @(negedge clk);
        rst = 1'b1;
        apply("add under rst",  4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000);
        apply("sub under rst",  4'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000);
        @(posedge clk);
        #1;
        check("res_q in rst",   res_q,            32'd0);
        check("flags_q in rst", {28'd0, flags_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
